// File: rtl/fir_pkg.sv
// Shared definitions for the adaptive FIR blocks.
//   DATA_W      : sample / coefficient width
//   lms_state_t : LMS update sequencer states
//   sat32()     : clamp a signed 64-bit value into the signed 32-bit range
package fir_pkg;

  localparam int DATA_W = 32;

  localparam logic signed [63:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_MIN = -64'sh0000_0000_8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    CALC_ERR,
    UPDATE,
    RELOAD,
    STREAM,
    DONE
  } lms_state_t;

  function automatic logic [DATA_W-1:0] sat32(input logic signed [63:0] v);
    if (v > SAT_MAX)      return 32'h7FFF_FFFF;
    else if (v < SAT_MIN) return 32'h8000_0000;
    else                  return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/fir_lms_mac.sv
// One-tap-per-cycle LMS coefficient update.
//   in_valid/in_idx/e/x : tap to update this cycle (error and snapshot sample)
//   w_cur               : current value of w[out_idx], looked up by the parent
//   out_valid/out_idx   : write strobe and tap index, one cycle after input
//   w_new               : sat32(w_cur + sat32((e*x) >>> MU_SHIFT))
// The scaled product is registered; the accumulate is combinational so the
// parent writes w[out_idx] <= w_new on the edge where out_valid is high.
module fir_lms_mac
  import fir_pkg::*;
#(
  parameter int MU_SHIFT = 8,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [31:0]      e,
  input  logic [31:0]      x,
  input  logic [31:0]      w_cur,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [31:0]      w_new
);

  logic signed [63:0] prod;
  logic signed [63:0] scaled;
  logic        [31:0] delta_d;
  logic        [31:0] delta_q;
  logic signed [32:0] sum;

  assign prod    = $signed({{32{e[31]}}, e}) * $signed({{32{x[31]}}, x});
  assign scaled  = prod >>> MU_SHIFT;
  assign delta_d = sat32(scaled);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      delta_q   <= '0;
    end else begin
      out_valid <= in_valid;
      out_idx   <= in_idx;
      delta_q   <= delta_d;
    end
  end

  // Both operands are already in 32-bit range, so a 33-bit sum cannot wrap.
  assign sum   = $signed({w_cur[31], w_cur}) + $signed({delta_q[31], delta_q});
  assign w_new = sat32({{31{sum[32]}}, sum});

endmodule

// File: rtl/fir_lms_update.sv
// LMS coefficient adaptation for the FIR datapath.
//   clk, rstn (sync, active-low)
//   tap_count        : requested tap count, clamped to MAX_TAPS on acceptance
//   enable           : gates acceptance of y_valid
//   x_valid/x_data   : input sample stream (feeds the history shift register)
//   y_valid/y_data/d_data : filter output and desired sample
//   error_valid/error_data : saturated error e = d - y of the last update
//   coeff_reload, coeff_data_valid/coeff_data, update_done : coefficient stream
//   busy, overrun (sticky, y_valid seen while busy)
// Sequence per accepted update: CALC_ERR, N x UPDATE, RELOAD, N x STREAM, DONE.
module fir_lms_update
  import fir_pkg::*;
#(
  parameter int MAX_TAPS = 16,
  parameter int MU_SHIFT = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] tap_count,
  input  logic        enable,
  input  logic        x_valid,
  input  logic [31:0] x_data,
  input  logic        y_valid,
  input  logic [31:0] y_data,
  input  logic [31:0] d_data,
  output logic        error_valid,
  output logic [31:0] error_data,
  output logic        coeff_reload,
  output logic        coeff_data_valid,
  output logic [31:0] coeff_data,
  output logic        update_done,
  output logic        busy,
  output logic        overrun
);

  localparam int IDX_W = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
  localparam int CNT_W = IDX_W + 1;  // holds 0..MAX_TAPS inclusive

  lms_state_t state, state_nx;

  logic [31:0] w      [MAX_TAPS];
  logic [31:0] x_hist [MAX_TAPS];
  logic [31:0] x_snap [MAX_TAPS];

  logic [CNT_W-1:0] fill;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] n_eff;
  logic [IDX_W-1:0] cnt;
  logic             last;
  logic             accept;
  logic [31:0]      y_q, d_q;
  logic signed [32:0] diff;

  logic             mac_valid;
  logic [IDX_W-1:0] mac_idx;
  logic [31:0]      mac_w_new;

  assign n_eff  = (tap_count > 32'(MAX_TAPS)) ? CNT_W'(MAX_TAPS) : tap_count[CNT_W-1:0];
  assign accept = (state == IDLE) && enable && y_valid &&
                  (n_eff != '0) && (fill >= n_eff);
  assign last   = (({1'b0, cnt} + CNT_W'(1)) == n_q);
  assign diff   = $signed({d_q[31], d_q}) - $signed({y_q[31], y_q});

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept) state_nx = CALC_ERR;
      CALC_ERR: state_nx = UPDATE;
      UPDATE:   if (last) state_nx = RELOAD;
      RELOAD:   state_nx = STREAM;
      STREAM:   if (last) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      fill        <= '0;
      n_q         <= '0;
      cnt         <= '0;
      y_q         <= '0;
      d_q         <= '0;
      error_valid <= 1'b0;
      error_data  <= '0;
      overrun     <= 1'b0;
      for (int i = 0; i < MAX_TAPS; i++) begin
        w[i]      <= '0;
        x_hist[i] <= '0;
        x_snap[i] <= '0;
      end
    end else begin
      state <= state_nx;

      if (x_valid) begin
        x_hist[0] <= x_data;
        for (int i = 1; i < MAX_TAPS; i++) x_hist[i] <= x_hist[i-1];
        if (fill != CNT_W'(MAX_TAPS)) fill <= fill + CNT_W'(1);
      end

      // Snapshot reads the pre-shift history when x_valid coincides.
      if (accept) begin
        n_q <= n_eff;
        y_q <= y_data;
        d_q <= d_data;
        for (int i = 0; i < MAX_TAPS; i++) x_snap[i] <= x_hist[i];
      end

      if (y_valid && (state != IDLE)) overrun <= 1'b1;

      // error_data doubles as the error operand of the MAC during UPDATE.
      error_valid <= 1'b0;
      if (state == CALC_ERR) begin
        error_valid <= 1'b1;
        error_data  <= sat32({{31{diff[32]}}, diff});
      end

      if ((state == UPDATE) || (state == STREAM)) cnt <= last ? '0 : cnt + IDX_W'(1);
      else                                        cnt <= '0;

      // MAC is one cycle behind UPDATE; the final tap lands during RELOAD.
      if (mac_valid) w[mac_idx] <= mac_w_new;
    end
  end

  fir_lms_mac #(
    .MU_SHIFT (MU_SHIFT),
    .IDX_W    (IDX_W)
  ) u_mac (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (state == UPDATE),
    .in_idx    (cnt),
    .e         (error_data),
    .x         (x_snap[cnt]),
    .w_cur     (w[mac_idx]),
    .out_valid (mac_valid),
    .out_idx   (mac_idx),
    .w_new     (mac_w_new)
  );

  assign coeff_reload     = (state == RELOAD);
  assign coeff_data_valid = (state == STREAM);
  assign coeff_data       = (state == STREAM) ? w[cnt] : '0;
  assign update_done      = (state == DONE);
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_fir_lms_update.sv
module tb_fir_lms_update;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] tap_count = 32'd4;
  logic        enable = 1'b1;
  logic        x_valid = 1'b0;
  logic [31:0] x_data = '0;
  logic        y_valid = 1'b0;
  logic [31:0] y_data = '0;
  logic [31:0] d_data = '0;

  logic        ev0, rl0, cdv0, dn0, busy0, ovr0;
  logic [31:0] ed0, cd0;
  logic        ev2, rl2, cdv2, dn2, busy2, ovr2;
  logic [31:0] ed2, cd2;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations of one update sequence (cycle 1 = first cycle after acceptance)
  int          ev_cyc, ev_cnt, rl_cyc, st_first, st_last, st_cnt, dn_cyc;
  logic [31:0] ev_data;
  logic [31:0] st0 [16];
  logic [31:0] st2 [16];

  always #5 clk = ~clk;

  fir_lms_update #(.MAX_TAPS(16), .MU_SHIFT(0)) u0 (
    .clk(clk), .rstn(rstn), .tap_count(tap_count), .enable(enable),
    .x_valid(x_valid), .x_data(x_data), .y_valid(y_valid), .y_data(y_data),
    .d_data(d_data), .error_valid(ev0), .error_data(ed0), .coeff_reload(rl0),
    .coeff_data_valid(cdv0), .coeff_data(cd0), .update_done(dn0),
    .busy(busy0), .overrun(ovr0));

  fir_lms_update #(.MAX_TAPS(16), .MU_SHIFT(2)) u2 (
    .clk(clk), .rstn(rstn), .tap_count(tap_count), .enable(enable),
    .x_valid(x_valid), .x_data(x_data), .y_valid(y_valid), .y_data(y_data),
    .d_data(d_data), .error_valid(ev2), .error_data(ed2), .coeff_reload(rl2),
    .coeff_data_valid(cdv2), .coeff_data(cd2), .update_done(dn2),
    .busy(busy2), .overrun(ovr2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic push_x(input logic [31:0] v);
    x_valid = 1'b1;
    x_data  = v;
    tick();
    x_valid = 1'b0;
  endtask

  // Drives one y_valid and records what the DUTs emit until busy drops.
  // inj_x / inj_y: cycle in which to pulse x_valid (x=100) / y_valid, 0 = none.
  task automatic do_update(input logic [31:0] d, input logic [31:0] y,
                           input int inj_x, input int inj_y);
    int k;
    ev_cyc = 0; ev_cnt = 0; ev_data = '0; rl_cyc = 0;
    st_first = 0; st_last = 0; st_cnt = 0; dn_cyc = 0;
    for (int j = 0; j < 16; j++) begin st0[j] = '0; st2[j] = '0; end
    y_valid = 1'b1; y_data = y; d_data = d;
    tick();
    y_valid = 1'b0;
    k = 1;
    while (busy0 && k <= 60) begin
      if (ev0) begin
        if (ev_cnt == 0) begin ev_cyc = k; ev_data = ed0; end
        ev_cnt++;
      end
      if (rl0) rl_cyc = k;
      if (cdv0 && st_cnt < 16) begin
        if (st_cnt == 0) st_first = k;
        st_last = k;
        st0[st_cnt] = cd0;
        st2[st_cnt] = cd2;
        st_cnt++;
      end
      if (dn0) dn_cyc = k;
      x_valid = (k == inj_x);
      x_data  = 32'd100;
      y_valid = (k == inj_y);
      tick();
      x_valid = 1'b0;
      y_valid = 1'b0;
      k++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    n_tests++;
    if ({ev0, rl0, cdv0, dn0, busy0, ovr0} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 000000", {ev0, rl0, cdv0, dn0, busy0, ovr0});
    end
    n_tests++;
    if ({ed0, cd0} !== 64'd0) begin
      n_fail++; $display("FAIL reset_data got err=%0h coeff=%0h want 0", ed0, cd0);
    end
  endtask

  task automatic test_basic();
    logic [31:0] e0 [4];
    logic [31:0] e2 [4];
    e0 = '{32'd32, 32'd24, 32'd16, 32'd8};
    e2 = '{32'd8, 32'd6, 32'd4, 32'd2};
    for (int v = 1; v <= 4; v++) push_x(32'(v));
    do_update(32'd8, 32'd0, 0, 0);
    n_tests++;
    if (ev_data !== 32'd8 || ev_cyc != 2 || ev_cnt != 1) begin
      n_fail++; $display("FAIL basic_err got %0h@%0d x%0d want 8@2 x1", ev_data, ev_cyc, ev_cnt);
    end
    n_tests++;
    if (rl_cyc != 6) begin n_fail++; $display("FAIL basic_reload got cyc %0d want 6", rl_cyc); end
    n_tests++;
    if (st_first != 7 || st_last != 10 || st_cnt != 4) begin
      n_fail++; $display("FAIL basic_stream_win got %0d..%0d n=%0d want 7..10 n=4", st_first, st_last, st_cnt);
    end
    n_tests++;
    if (dn_cyc != 11) begin n_fail++; $display("FAIL basic_done got cyc %0d want 11", dn_cyc); end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (st0[j] !== e0[j]) begin n_fail++; $display("FAIL basic_w%0d_mu0 got %0d want %0d", j, st0[j], e0[j]); end
      n_tests++;
      if (st2[j] !== e2[j]) begin n_fail++; $display("FAIL basic_w%0d_mu2 got %0d want %0d", j, st2[j], e2[j]); end
    end
  endtask

  task automatic test_step();
    logic [31:0] e0 [4];
    logic [31:0] e2 [4];
    e0 = '{32'd64, 32'd48, 32'd32, 32'd16};
    e2 = '{32'd16, 32'd12, 32'd8, 32'd4};
    do_update(32'd8, 32'd0, 0, 0);
    n_tests++;
    if (dn_cyc != 11 || ed2 !== 32'd8) begin
      n_fail++; $display("FAIL step_done got cyc %0d err2=%0d want 11 / 8", dn_cyc, ed2);
    end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (st0[j] !== e0[j]) begin n_fail++; $display("FAIL step_w%0d_mu0 got %0d want %0d", j, st0[j], e0[j]); end
      n_tests++;
      if (st2[j] !== e2[j]) begin n_fail++; $display("FAIL step_w%0d_mu2 got %0d want %0d", j, st2[j], e2[j]); end
    end
  endtask

  task automatic test_fill_gate();
    logic [31:0] e0 [4];
    logic        seen;
    e0 = '{32'd32, 32'd24, 32'd16, 32'd8};
    do_reset();
    for (int v = 1; v <= 3; v++) push_x(32'(v));
    y_valid = 1'b1; y_data = 0; d_data = 8;
    tick();
    y_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      seen = seen | busy0 | cdv0 | rl0;
      tick();
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL fill_gate got busy/stream %b want 0", seen); end
    push_x(32'd4);
    // fill is now sufficient but adaptation is disabled
    enable = 1'b0;
    y_valid = 1'b1;
    tick();
    y_valid = 1'b0;
    enable = 1'b1;
    n_tests++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL enable_gate got busy %b want 0", busy0); end
    do_update(32'd8, 32'd0, 0, 0);
    n_tests++;
    if (dn_cyc != 11) begin n_fail++; $display("FAIL fill_done got cyc %0d want 11", dn_cyc); end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (st0[j] !== e0[j]) begin n_fail++; $display("FAIL fill_w%0d got %0d want %0d", j, st0[j], e0[j]); end
    end
  endtask

  // Runs after test_fill_gate: w = 32,24,16,8 and x history = 4,3,2,1.
  task automatic test_saturation();
    do_update(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    n_tests++;
    if (ev_data !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_err_pos got %0h want 7fffffff", ev_data); end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (st0[j] !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_wpos%0d got %0h want 7fffffff", j, st0[j]); end
    end
    do_update(32'h8000_0000, 32'd1, 0, 0);
    n_tests++;
    if (ev_data !== 32'h8000_0000) begin n_fail++; $display("FAIL sat_err_neg got %0h want 80000000", ev_data); end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (st0[j] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_wmid%0d got %0h want ffffffff", j, st0[j]); end
    end
    do_update(32'h8000_0000, 32'd1, 0, 0);
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (st0[j] !== 32'h8000_0000) begin n_fail++; $display("FAIL sat_wneg%0d got %0h want 80000000", j, st0[j]); end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] e0 [4];
    e0 = '{32'd32, 32'd24, 32'd16, 32'd8};
    do_reset();
    n_tests++;
    if (ovr0 !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", ovr0); end
    for (int v = 1; v <= 4; v++) push_x(32'(v));
    // x_valid in UPDATE (cycle 3), y_valid in STREAM (cycle 8)
    do_update(32'd8, 32'd0, 3, 8);
    n_tests++;
    if (ovr0 !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", ovr0); end
    n_tests++;
    if (dn_cyc != 11 || st_cnt != 4) begin
      n_fail++; $display("FAIL ovr_done got cyc %0d n=%0d want 11 n=4", dn_cyc, st_cnt);
    end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (st0[j] !== e0[j]) begin n_fail++; $display("FAIL ovr_w%0d got %0d want %0d", j, st0[j], e0[j]); end
    end
    tick(); tick();
    n_tests++;
    if (busy0 !== 1'b0 || ovr0 !== 1'b1) begin
      n_fail++; $display("FAIL ovr_after got busy=%b ovr=%b want 0 1", busy0, ovr0);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [31:0] e0 [4];
    int          k;
    e0 = '{32'd32, 32'd24, 32'd16, 32'd8};
    do_reset();
    for (int v = 1; v <= 4; v++) push_x(32'(v));
    y_valid = 1'b1; y_data = 0; d_data = 8;
    tick();
    y_valid = 1'b0;
    k = 0;
    while (!cdv0 && k < 20) begin tick(); k++; end
    n_tests++;
    if (cdv0 !== 1'b1) begin n_fail++; $display("FAIL mid_reach_stream got %b want 1", cdv0); end
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n_tests++;
    if ({ev0, rl0, cdv0, dn0, busy0, ovr0} !== 6'b0) begin
      n_fail++; $display("FAIL mid_reset_flags got %b want 000000", {ev0, rl0, cdv0, dn0, busy0, ovr0});
    end
    n_tests++;
    if ({ed0, cd0} !== 64'd0) begin
      n_fail++; $display("FAIL mid_reset_data got err=%0h coeff=%0h want 0", ed0, cd0);
    end
    for (int v = 1; v <= 4; v++) push_x(32'(v));
    do_update(32'd8, 32'd0, 0, 0);
    n_tests++;
    if (dn_cyc != 11) begin n_fail++; $display("FAIL mid_done got cyc %0d want 11", dn_cyc); end
    for (int j = 0; j < 4; j++) begin
      n_tests++;
      if (st0[j] !== e0[j]) begin n_fail++; $display("FAIL mid_w%0d got %0d want %0d", j, st0[j], e0[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_step();
    test_fill_gate();
    test_saturation();
    test_overrun();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_lms_update.md
Name: fir_lms_update

Overview:
- Adaptive-side counterpart of the FIR datapath.
- Consumes the filter's output stream and a desired-response stream, and computes error e = d - y.
- Updates an internal coefficient set with the sign-preserving LMS rule w[i] += (e*x[i]) >>> MU_SHIFT.
- Streams the updated coefficients back out on a coeff valid/data interface that the control unit forwards into the datapath.

Parameters:
MAX_TAPS, 16, maximum filter length; size of the coefficient and history arrays
MU_SHIFT, 8, step size as an arithmetic right shift of e*x (mu = 2^-MU_SHIFT)

Ports:
clk  in  1  clock; all logic on posedge
rstn  in  1  reset, synchronous, active-low
tap_count  in  32  active tap count N (unsigned); sampled only in IDLE
enable  in  1  adaptation enable; gates acceptance of y_valid
x_valid  in  1  input sample strobe (same strobe/data fed to the datapath)
x_data  in  32  signed input sample
y_valid  in  1  filter output strobe (datapath output valid)
y_data  in  32  signed filter output
d_data  in  32  signed desired sample, qualified by y_valid
error_valid  out  1  one-cycle pulse; error_data is new
error_data  out  32  signed saturated error of last accepted update
coeff_reload  out  1  one-cycle pulse preceding a coefficient stream
coeff_data_valid  out  1  high for each streamed coefficient
coeff_data  out  32  signed coefficient, w[0] first
update_done  out  1  one-cycle pulse after the last coefficient
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky; y_valid arrived while busy; cleared only by reset

Behaviour:
- Reset (rstn=0 at posedge): state IDLE.
  - All outputs 0; overrun 0.
  - All w[i] and x_hist[i] = 0; fill counter 0.
- Effective N = min(tap_count, MAX_TAPS), latched on acceptance. When N=0, y_valid is ignored and the block stays IDLE.
- History:
  - On x_valid, in every state, x_hist shifts: x_hist[0] = x_data (newest), x_hist[i] = old x_hist[i-1].
  - The fill counter increments on x_valid and saturates at MAX_TAPS.
- Acceptance at edge T requires all of: state IDLE, enable, y_valid, and fill >= N. On acceptance:
  - y_data and d_data are latched.
  - x_snap[0..N-1] = x_hist[0..N-1] is taken, pre-shift if x_valid coincides.
  - If y_valid arrives with fill < N or enable=0, it is dropped silently.
- y_valid while busy: the event is dropped and overrun is set.
- FSM, one state step per cycle:
  - IDLE -> CALC_ERR on acceptance.
  - CALC_ERR (cycle T+1): e = sat32(d - y), computed 33-bit and then saturated.
  - UPDATE (cycles T+2..T+1+N): index i = 0..N-1, one tap per cycle.
    - prod = e * x_snap[i], 64-bit signed.
    - delta = prod >>> MU_SHIFT, truncated to 33 bits after saturation to the 32-bit range.
    - w[i] = sat32(w[i] + delta).
    - error_valid pulses and error_data updates in the first UPDATE cycle; error_data then holds.
  - RELOAD (T+2+N): coeff_reload = 1.
  - STREAM (T+3+N..T+2+2N): coeff_data_valid = 1, coeff_data = w[j], j = 0..N-1 consecutively, no gaps.
  - DONE (T+3+2N): update_done = 1, then IDLE.
- Total busy window: 2N+3 cycles.
- Taps i >= N are never updated or streamed and keep their values.
- Saturation: positive overflow -> 32'h7FFFFFFF; negative -> 32'h80000000.
- Reset mid-operation:
  - Aborts immediately to IDLE with the reset values above.
  - Coefficients are lost; a partial stream is never resumed.
- enable deasserted while busy: the current update completes.

Decomposition:
- Shared package fir_pkg:
  - sat32 function
  - state enum lms_state_t {IDLE, CALC_ERR, UPDATE, RELOAD, STREAM, DONE}
  - DATA_W = 32 constant
- One sub-module, fir_lms_mac: registered e*x >>> MU_SHIFT plus saturating accumulate, one tap per cycle.
- The FSM, history and snapshot stay in the top module.

Test Plan:
- Basic update: N=4, MU_SHIFT=0, x = 1,2,3,4, then y=0, d=8.
  - error_data = 8.
  - coeff_reload, then coeff_data = 32,24,16,8 on 4 consecutive cycles.
  - update_done at T+11.
- Step size: same stimulus with MU_SHIFT=2 -> stream 8,6,4,2. Second identical update -> 16,12,8,4.
- Fill gate: N=4, only 3 x_valid, then y_valid -> no busy, no stream. One more x_valid plus y_valid -> update proceeds.
- Saturation:
  - d = 32'h7FFFFFFF, y = -1 -> error_data = 32'h7FFFFFFF.
  - With w[0] near max and positive x, w[0] clamps to 32'h7FFFFFFF.
- Overrun and concurrency:
  - y_valid during STREAM -> overrun = 1 and the event is ignored.
  - x_valid during UPDATE does not alter the streamed values.
- Reset mid-STREAM: rstn low for 1 cycle -> outputs 0, busy 0. The next update from zero coefficients matches the basic case.
